// File: rtl/anc_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | anc_arb_pkg                                                            |
// | Shared types and constants for the ANC FIR arbiter slice.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package anc_arb_pkg;

  localparam int ANC_NCH = 2;   // number of requesting channels
  localparam int ANC_DW  = 16;  // default sample / weight-adjust width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Channel index to one-hot channel mask.
  function automatic logic [ANC_NCH-1:0] ch_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anc_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | anc_rr_arbiter                                                         |
// | Combinational two-way round-robin pick.                                |
// | Revision: 1.0                                                          |
// | Ports:                                                                 |
// |   req_valid  in  2  per-channel request                                |
// |   last_grant in  1  channel served most recently                       |
// |   grant      out 2  one-hot grant (0 when nobody requests)             |
// |   grant_idx  out 1  granted channel index                              |
// +------------------------------------------------------------------------+
module anc_rr_arbiter
  import anc_arb_pkg::*;
(
  input  logic [ANC_NCH-1:0] req_valid,
  input  logic               last_grant,
  output logic [ANC_NCH-1:0] grant,
  output logic               grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    grant     = '0;
    if (&req_valid) begin
      // Contention: the channel not served last time wins.
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req_valid[1];
    end
    if (|req_valid) begin
      grant = ch_onehot(grant_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/anc_fir_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | anc_fir_arbiter                                                        |
// | Shares one FIR datapath between two ANC requesters. Grants round-robin,|
// | launches the FIR with a one-cycle fir_go, waits for fir_done and hands |
// | the captured output sample back over a valid/ready handshake.          |
// | Revision: 1.0                                                          |
// | Optional feature: define ANC_ARB_WATCHDOG_EN to build the BUSY         |
// | watchdog (resp_err / timeout_flag); otherwise both are tied to 0.      |
// | Ports:                                                                 |
// |   clk, rst (async, active-high)                                        |
// |   req_valid/req_ready [2], req_x/req_a/req_wadj [2*DW] packed by chan  |
// |   resp_valid [2], resp_ready [2], resp_sample [DW], resp_err           |
// |   fir_go, fir_x/fir_a/fir_wadj [DW], fir_done, fir_out_valid,          |
// |   fir_out_sample [DW]                                                  |
// |   busy, timeout_flag                                                   |
// +------------------------------------------------------------------------+
module anc_fir_arbiter
  import anc_arb_pkg::*;
#(
  parameter int DW        = ANC_DW,
  parameter int WD_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANC_NCH-1:0]    req_valid,
  output logic [ANC_NCH-1:0]    req_ready,
  input  logic [ANC_NCH*DW-1:0] req_x,
  input  logic [ANC_NCH*DW-1:0] req_a,
  input  logic [ANC_NCH*DW-1:0] req_wadj,
  output logic [ANC_NCH-1:0]    resp_valid,
  input  logic [ANC_NCH-1:0]    resp_ready,
  output logic [DW-1:0]         resp_sample,
  output logic                  resp_err,
  output logic                  fir_go,
  output logic [DW-1:0]         fir_x,
  output logic [DW-1:0]         fir_a,
  output logic [DW-1:0]         fir_wadj,
  input  logic                  fir_done,
  input  logic                  fir_out_valid,
  input  logic [DW-1:0]         fir_out_sample,
  output logic                  busy,
  output logic                  timeout_flag
);

  arb_state_t           state;
  logic                 g;           // channel of the job in flight
  logic                 last_grant;
  logic [ANC_NCH-1:0]   grant;
  logic                 grant_idx;
  logic                 accept;
  logic                 wd_expire;

  anc_rr_arbiter u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Held low while rst is asserted so every output reads 0 during reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      g           <= 1'b0;
      last_grant  <= 1'b1;  // channel 0 wins the first contention
      fir_go      <= 1'b0;
      fir_x       <= '0;
      fir_a       <= '0;
      fir_wadj    <= '0;
      resp_sample <= '0;
      resp_valid  <= '0;
      busy        <= 1'b0;
    end else begin
      fir_go <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            g           <= grant_idx;
            fir_x       <= grant_idx ? req_x[2*DW-1:DW]    : req_x[DW-1:0];
            fir_a       <= grant_idx ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
            fir_wadj    <= grant_idx ? req_wadj[2*DW-1:DW] : req_wadj[DW-1:0];
            fir_go      <= 1'b1;
            resp_sample <= '0;   // result register starts clean for each job
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          // Last strobe wins, including one coincident with fir_done.
          if (fir_out_valid) resp_sample <= fir_out_sample;
          if (fir_done) begin
            resp_valid <= ch_onehot(g);
            state      <= RESP;
          end else if (wd_expire) begin
            resp_sample <= '0;
            resp_valid  <= ch_onehot(g);
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[g]) begin
            resp_valid <= '0;
            last_grant <= g;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ANC_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES) + 1;

  logic [WDW-1:0] wd_cnt;
  logic           err_q;
  logic           tmo_q;

  // Expires on the WD_CYCLES-th BUSY cycle; a coincident fir_done wins.
  assign wd_expire = (state == BUSY) && !fir_done &&
                     (wd_cnt == WDW'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == BUSY) wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) begin
        err_q <= 1'b1;
        tmo_q <= 1'b1;
      end else if (state == RESP && resp_ready[g]) begin
        err_q <= 1'b0;
      end
    end
  end

  assign resp_err     = err_q;
  assign timeout_flag = tmo_q;
`else
  assign wd_expire    = 1'b0;
  assign resp_err     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_anc_fir_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_anc_fir_arbiter                                                     |
// | Directed self-checking bench for anc_fir_arbiter.                      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_anc_fir_arbiter;
  import anc_arb_pkg::*;

  localparam int DW = 16;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [2*DW-1:0] req_x, req_a, req_wadj;
  logic [DW-1:0] resp_sample, fir_x, fir_a, fir_wadj, fir_out_sample;
  logic          resp_err, fir_go, fir_done, fir_out_valid, busy, timeout_flag;

  int total = 0;
  int bad   = 0;

  anc_fir_arbiter #(.DW(DW), .WD_CYCLES(WD)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_x          (req_x),
    .req_a          (req_a),
    .req_wadj       (req_wadj),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_sample    (resp_sample),
    .resp_err       (resp_err),
    .fir_go         (fir_go),
    .fir_x          (fir_x),
    .fir_a          (fir_a),
    .fir_wadj       (fir_wadj),
    .fir_done       (fir_done),
    .fir_out_valid  (fir_out_valid),
    .fir_out_sample (fir_out_sample),
    .busy           (busy),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_fir_go"}, 32'(fir_go), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_resp_sample"}, 32'(resp_sample), 0);
    chk({tag, "_fir_x"}, 32'(fir_x), 0);
    chk({tag, "_fir_a"}, 32'(fir_a), 0);
    chk({tag, "_fir_wadj"}, 32'(fir_wadj), 0);
    chk({tag, "_resp_err"}, 32'(resp_err), 0);
    chk({tag, "_timeout"}, 32'(timeout_flag), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // One job on a channel that is currently granted; FIR finishes one cycle
  // into BUSY with result res.
  task automatic job(input string tag, input int ch, input logic [15:0] xexp,
                     input logic [15:0] res);
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << ch));
    step();                                   // T+1: ISSUE
    chk({tag, "_go"}, 32'(fir_go), 1);
    chk({tag, "_fir_x"}, 32'(fir_x), 32'(xexp));
    chk({tag, "_ready_issue"}, 32'(req_ready), 0);
    step();                                   // T+2: BUSY
    chk({tag, "_go_low"}, 32'(fir_go), 0);
    fir_out_valid  = 1'b1;
    fir_out_sample = res;
    fir_done       = 1'b1;
    step();                                   // D+1: RESP
    fir_out_valid  = 1'b0;
    fir_done       = 1'b0;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(1 << ch));
    chk({tag, "_resp_sample"}, 32'(resp_sample), 32'(res));
    resp_ready = 2'b11;
    step();                                   // back in IDLE
    resp_ready = 2'b00;
    chk({tag, "_busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 2'b00;
    resp_ready     = 2'b00;
    req_x          = '0;
    req_a          = '0;
    req_wadj       = '0;
    fir_done       = 1'b0;
    fir_out_valid  = 1'b0;
    fir_out_sample = '0;

    // ---- reset state, including a request presented during reset ----
    step();
    req_valid = 2'b11;
    #1;
    all_zero("rst");
    req_valid = 2'b00;
    rst = 1'b0;
    #1;

    // ---- single job on ch0, last strobe wins ----
    req_x    = {16'h0B00, 16'h0100};
    req_a    = {16'h0C00, 16'h0200};
    req_wadj = {16'h0D00, 16'h0010};
    req_valid = 2'b01;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step();                                   // T+1
    req_valid = 2'b00;
    chk("single_go", 32'(fir_go), 1);
    chk("single_fir_x", 32'(fir_x), 32'h0100);
    chk("single_fir_a", 32'(fir_a), 32'h0200);
    chk("single_fir_wadj", 32'(fir_wadj), 32'h0010);
    chk("single_busy", 32'(busy), 1);
    step();                                   // T+2 BUSY
    chk("single_go_low", 32'(fir_go), 0);
    fir_out_valid  = 1'b1;
    fir_out_sample = 16'h1111;
    step();
    fir_out_valid = 1'b0;
    step();
    chk("single_no_resp_yet", 32'(resp_valid), 0);
    fir_out_valid  = 1'b1;
    fir_out_sample = 16'h1234;
    fir_done       = 1'b1;
    step();                                   // D+1
    fir_out_valid = 1'b0;
    fir_done      = 1'b0;
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_sample", 32'(resp_sample), 32'h1234);
    chk("single_resp_err", 32'(resp_err), 0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_valid", 32'(resp_valid), 0);

    // ---- contention after reset: ch0, ch1, ch0, ch1 ----
    do_reset();
    req_x     = {16'h0B00, 16'h0A00};
    req_valid = 2'b11;
    #1;
    job("cont0", 0, 16'h0A00, 16'h5000);
    #1;
    job("cont1", 1, 16'h0B00, 16'h5001);
    #1;
    job("cont2", 0, 16'h0A00, 16'h5002);
    #1;
    job("cont3", 1, 16'h0B00, 16'h5003);
    req_valid = 2'b00;

    // ---- response backpressure on ch0 while ch1 waits ----
    do_reset();
    req_valid = 2'b01;
    #1;
    step();                                   // ISSUE
    req_valid = 2'b10;
    step();                                   // BUSY
    fir_out_valid  = 1'b1;
    fir_out_sample = 16'h00BE;
    fir_done       = 1'b1;
    step();                                   // RESP
    fir_out_valid = 1'b0;
    fir_done      = 1'b0;
    resp_ready    = 2'b10;                    // non-granted ready is ignored
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_sample", 32'(resp_sample), 32'h00BE);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_no_accept", 32'(req_ready), 0);
      step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_valid", 32'(resp_valid), 0);
    chk("bp_ch1_next", 32'(req_ready), 32'h2);
    req_valid = 2'b00;

    // ---- reset in BUSY, then a fresh ch1 job ----
    do_reset();
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    step();                                   // BUSY
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    all_zero("mid_rst");
    step();
    rst = 1'b0;
    step();
    chk("mid_no_resp", 32'(resp_valid), 0);
    req_valid = 2'b10;
    #1;
    job("fresh1", 1, 16'h0B00, 16'h7777);
    req_valid = 2'b00;

    // ---- FIR never completes ----
    do_reset();
    req_valid = 2'b01;
    #1;
    step();                                   // T+1
    req_valid = 2'b00;
    step();                                   // T+2: first BUSY cycle
`ifdef ANC_ARB_WATCHDOG_EN
    repeat (15) step();                       // T+17: 16th BUSY cycle
    chk("wd_not_yet", 32'(resp_valid), 0);
    step();                                   // T+18
    chk("wd_resp_valid", 32'(resp_valid), 32'h1);
    chk("wd_resp_sample", 32'(resp_sample), 0);
    chk("wd_resp_err", 32'(resp_err), 1);
    chk("wd_timeout", 32'(timeout_flag), 1);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    #1;
    job("wd_after", 1, 16'h0B00, 16'h4321);
    req_valid = 2'b00;
    chk("wd_sticky", 32'(timeout_flag), 1);
`else
    repeat (10000) step();
    chk("nowd_busy", 32'(busy), 1);
    chk("nowd_resp_valid", 32'(resp_valid), 0);
    chk("nowd_resp_err", 32'(resp_err), 0);
    chk("nowd_timeout", 32'(timeout_flag), 0);
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
